// File: rtl/fifo_tile_reader_pkg.sv
// Shared definitions for the control-FIFO tile reader: FSM states,
// default geometry and the output queue depth.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_e;

    localparam int DEF_DW         = 256;
    localparam int DEF_LEN_W      = 16;
    localparam int DEF_TILE_WORDS = 32;

    // Words that may be queued or in flight from the FIFO at once.
    localparam int QUEUE_DEPTH    = 2;

endpackage

// File: rtl/fifo_tile_reader_if.sv
// Bus bundle between the control FIFO, the tile reader and the PE-array
// input. master = reader side, slave = FIFO/consumer side.
interface fifo_tile_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic          fifo_empty;
    logic          fifo_rdreq;
    logic [DW-1:0] fifo_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        input  fifo_empty, fifo_q, out_ready,
        output fifo_rdreq, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_empty, fifo_q, out_ready,
        input  fifo_rdreq, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_tile_reader_queue.sv
// Two-entry word queue with push/pop/count. The head entry is a register
// that drives the output directly, so data stays put while not popped.
module tile_out_queue #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         head_valid,
    output logic [W-1:0] head_data
);
    logic [W-1:0] ent0, ent1;

    assign head_valid = (count != 2'd0);
    assign head_data  = ent0;

    // Shift-style storage: ent0 is always the oldest word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_data;
                    else               ent1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind any survivor.
                    if (count == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_tile_reader.sv
// Tile reader: pops cfg_len words from the control FIFO, queues them in a
// 2-entry buffer and streams them out with out_last on tile boundaries.
// Optional stall counters are built when FIFO_TILE_READER_STATS_EN is defined.
module fifo_tile_reader
    import fifo_reader_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int TILE_WORDS = DEF_TILE_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    fifo_tile_reader_if.master bus
`ifdef FIFO_TILE_READER_STATS_EN
    ,
    output logic [31:0]      stall_empty_cnt,
    output logic [31:0]      stall_bp_cnt
`endif
);
    localparam int TCW = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
    localparam logic [TCW-1:0] TILE_LAST = TCW'(TILE_WORDS - 1);

    rd_state_e        state, nxt;
    logic [LEN_W-1:0] rd_remain, wr_remain;
    logic [TCW-1:0]   tile_cnt;
    logic             inflight;
    logic [1:0]       q_count;
    logic             hs, accept;

    assign hs     = bus.out_valid & bus.out_ready;
    assign accept = (state == IDLE) & start;

    assign bus.out_last = bus.out_valid &
                          ((tile_cnt == TILE_LAST) || (wr_remain == LEN_W'(1)));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next state, status outputs and the read-issue decision.
    always_comb begin
        nxt            = state;
        busy           = (state != IDLE);
        done           = (state == DONE);
        bus.fifo_rdreq = (state == RUN) && !bus.fifo_empty && (rd_remain != '0) &&
                         (({1'b0, q_count} + {2'b0, inflight}) < 3'(QUEUE_DEPTH));
        case (state)
            IDLE:    if (start) nxt = (cfg_len == '0) ? DONE : RUN;
            RUN:     if (rd_remain == '0) nxt = DRAIN;
            DRAIN:   if ((wr_remain == '0) || (hs && wr_remain == LEN_W'(1))) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Read/write down-counters and the tile position; both stop at zero
    // because reads and handshakes are gated by the remaining counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_remain <= '0;
            wr_remain <= '0;
            tile_cnt  <= '0;
        end else if (accept) begin
            rd_remain <= cfg_len;
            wr_remain <= cfg_len;
            tile_cnt  <= '0;
        end else begin
            if (bus.fifo_rdreq) rd_remain <= rd_remain - LEN_W'(1);
            if (hs) begin
                wr_remain <= wr_remain - LEN_W'(1);
                tile_cnt  <= (tile_cnt == TILE_LAST) ? '0 : tile_cnt + TCW'(1);
            end
        end
    end

    // FIFO data is valid the cycle after the request; capture it then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= bus.fifo_rdreq;
    end

    tile_out_queue #(.W(DW)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (bus.fifo_q),
        .pop        (hs),
        .count      (q_count),
        .head_valid (bus.out_valid),
        .head_data  (bus.out_data)
    );

`ifdef FIFO_TILE_READER_STATS_EN
    // Saturating stall counters, cleared per command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_empty_cnt <= '0;
            stall_bp_cnt    <= '0;
        end else if (accept) begin
            stall_empty_cnt <= '0;
            stall_bp_cnt    <= '0;
        end else begin
            if ((state == RUN) && bus.fifo_empty && !(&stall_empty_cnt))
                stall_empty_cnt <= stall_empty_cnt + 32'd1;
            if (bus.out_valid && !bus.out_ready && !(&stall_bp_cnt))
                stall_bp_cnt <= stall_bp_cnt + 32'd1;
        end
    end
`endif

endmodule
